lvds_cmd_dispatch: RTL
======================

// Module: lvds_cmd_dispatch
// PURPOSE
//  Downstream consumer of the LVDS remote-IO link endpoint, in the `clock` domain.
//  Decodes each received 40-bit word (wvalid/wdata) into a local register-bus write or read.
//  Returns read data on rdata; the link endpoint samples rdata ~127 clock cycles after wvalid.
//  Discards calibration words (wdata[39:32]==0), which the endpoint handles itself.
// PARAMETERS
//  TIMEOUT  64  clock cycles to wait for rd_valid after rd_en; legal range 2..100
//  TO_DATA  32'hFFFF_FFFF  value placed on rdata when a read times out
// PORTS
//  clock      in   1   system clock; all logic on posedge
//  rst_n      in   1   asynchronous active-low reset
//  wvalid     in   1   1-cycle strobe: wdata holds a new received word
//  wdata      in   40  [39]=read flag, [38:32]=address, [31:0]=write data
//  rdata      out  32  read response to link endpoint; held until next read completes
//  wr_en      out  1   1-cycle register write strobe
//  rd_en      out  1   1-cycle register read strobe
//  addr       out  7   register address, valid with wr_en/rd_en and held until next command
//  wr_data    out  32  register write data, valid with wr_en
//  rd_valid   in   1   read data ready; 1 or more cycles after rd_en, any rd_valid outside READ_WAIT ignored
//  rd_data    in   32  read data, sampled when rd_valid=1 in READ_WAIT
//  busy       out  1   1 while state != IDLE
//  err_to     out  8   saturating count of read timeouts
//  err_ovr    out  8   saturating count of words dropped while busy
// BEHAVIOUR
//  Reset (async assert, sync release) sets all outputs and registers to 0 and state to IDLE.
//  Decode on wvalid in IDLE:
//   - wdata[39:32]==0: calibration; ignore; no strobe; state stays IDLE.
//   - wdata[39]==0 with nonzero address: write.
//   - wdata[39]==1: read; address 0 with read flag (wdata[39:32]==8'h80) is a legal read of reg 0.
//  States: IDLE, WRITE, READ_WAIT, DONE.
//   IDLE -> WRITE: write decoded. Latch addr and wr_data; at the WRITE cycle, wr_en=1 for exactly one cycle.
//     wr_en is high on cycle N+1 when wvalid is on cycle N.
//   WRITE -> IDLE: next cycle.
//   IDLE -> READ_WAIT: read decoded. Latch addr; rd_en=1 on cycle N+1 for one cycle;
//     a down-counter loads TIMEOUT.
//   READ_WAIT, rd_valid=1: rdata<=rd_data and go to DONE; rd_valid on the rd_en cycle itself counts.
//   READ_WAIT, counter reaches 0 without rd_valid: rdata<=TO_DATA, err_to++ (saturate 255), go to DONE.
//   rd_valid and timeout in the same cycle: rd_valid wins; err_to unchanged.
//   DONE -> IDLE: next cycle. Worst-case read latency is TIMEOUT+2 cycles, below the endpoint sample point.
//  wvalid while state != IDLE: word dropped, err_ovr++ (saturate 255), no other effect.
//  wvalid on the same cycle the FSM returns to IDLE (state==DONE or WRITE) is also dropped.
//  rdata only changes on read completion; writes and calibration words leave it unchanged.
//  Reset mid-read: state returns to IDLE and rdata is cleared to 0; a late rd_valid after release is ignored.
//  wr_en and rd_en are never high together; at most one strobe per accepted word.
// TESTING
//  1. wvalid, wdata=40'h05_1234_5678 -> next cycle wr_en=1, addr=5, wr_data=32'h12345678; rdata unchanged.
//  2. wdata=40'h83_0000_0000 with rd_valid 3 cycles after rd_en, rd_data=32'hCAFEF00D
//     -> addr=3, rdata=32'hCAFEF00D, busy falls 1 cycle later.
//  3. Read with rd_valid never asserted -> rdata=32'hFFFFFFFF after TIMEOUT+1 cycles, err_to=1;
//     300 timeouts -> err_to=255.
//  4. wdata=40'h00_0101_0000 (calibration) -> no wr_en/rd_en, busy=0, counters unchanged.
//  5. Second wvalid 2 cycles into a read -> err_ovr=1, the first read still completes, no second rd_en.
//  6. rst_n low during READ_WAIT -> outputs 0 immediately (async);
//     a rd_valid after release leaves rdata=0, and the next write is accepted normally.

Source files
------------

// File: rtl/lvds_cmd_dispatch.sv
// rtl/lvds_cmd_dispatch.sv - LVDS link word decoder driving a local register bus
//
// Turns each 40-bit word received from the LVDS endpoint into one register
// write or read. Read data is returned on rdata well before the endpoint
// samples it. Calibration words (top byte zero) are ignored.
//
// Ports:
//   clock, rst_n        clock and asynchronous active-low reset
//   wvalid, wdata[39:0] received word strobe; [39]=read, [38:32]=addr, [31:0]=data
//   rdata[31:0]         last read result (or TO_DATA on timeout)
//   wr_en, rd_en        one-cycle register bus strobes
//   addr[6:0]           register address, held until the next command
//   wr_data[31:0]       register write data
//   rd_valid, rd_data   register read response
//   busy                command in progress
//   err_to, err_ovr     saturating timeout / dropped-word counters

module lvds_cmd_dispatch #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic [31:0] TO_DATA = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        wvalid,
  input  logic [39:0] wdata,
  output logic [31:0] rdata,
  output logic        wr_en,
  output logic        rd_en,
  output logic [6:0]  addr,
  output logic [31:0] wr_data,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic [7:0]  err_to,
  output logic [7:0]  err_ovr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [6:0] TO_LOAD = 7'(TIMEOUT);

  state_t      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        rd_en_q, rd_en_d;
  logic [7:0]  err_to_q, err_to_d;
  logic [7:0]  err_ovr_q, err_ovr_d;
  logic        is_cal;

  assign is_cal = (wdata[39:32] == 8'h00);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    rd_en_d   = 1'b0;
    err_to_d  = err_to_q;
    err_ovr_d = err_ovr_q;

    case (state_q)
      IDLE: begin
        if (wvalid && !is_cal) begin
          addr_d = wdata[38:32];
          if (wdata[39]) begin
            state_d = READ_WAIT;
            rd_en_d = 1'b1;
            cnt_d   = TO_LOAD;
          end else begin
            wr_data_d = wdata[31:0];
            state_d   = WRITE;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ_WAIT: begin
        // rd_valid is checked first so a response on the final counted
        // cycle beats the timeout.
        if (rd_valid) begin
          rdata_d = rd_data;
          state_d = DONE;
        end else if (cnt_q <= 7'd1) begin
          rdata_d = TO_DATA;
          cnt_d   = 7'd0;
          state_d = DONE;
          if (err_to_q != 8'hFF) begin
            err_to_d = err_to_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - 7'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Words arriving in any non-IDLE state, including the cycle the FSM
    // is about to return to IDLE, are dropped and counted.
    if (wvalid && (state_q != IDLE) && (err_ovr_q != 8'hFF)) begin
      err_ovr_d = err_ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= 7'd0;
      wr_data_q <= 32'd0;
      rdata_q   <= 32'd0;
      cnt_q     <= 7'd0;
      rd_en_q   <= 1'b0;
      err_to_q  <= 8'd0;
      err_ovr_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      rd_en_q   <= rd_en_d;
      err_to_q  <= err_to_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  // The WRITE state lasts exactly one cycle, so it doubles as the strobe.
  assign wr_en   = (state_q == WRITE);
  assign rd_en   = rd_en_q;
  assign addr    = addr_q;
  assign wr_data = wr_data_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != IDLE);
  assign err_to  = err_to_q;
  assign err_ovr = err_ovr_q;

endmodule
